// File: rtl/sync_up_counter.sv
// rtl/sync_up_counter.sv - synchronous modulo-N up-counter with load, tc/carry cascade outputs and wrap counter
// Optional saturating mode: define SYNC_UP_COUNTER_SAT_EN.
module sync_up_counter #(
    parameter int WIDTH   = 6,
    parameter int MODULUS = 64,
    parameter int WRAPW   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_n,
    output logic             tc,
    output logic             carry,
    output logic             load_err,
    output logic [WRAPW-1:0] wrap_cnt
);

    // Compares run one bit wider so MODULUS == 2**WIDTH stays representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   TOP_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] TOP     = TOP_EXT[WIDTH-1:0];

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("sync_up_counter: MODULUS out of range 2..2**WIDTH");
    end

    logic at_top;
    logic load_oor;

    assign at_top   = ({1'b0, count} == TOP_EXT);
    assign load_oor = ({1'b0, load_val} >= MOD_EXT);
    assign tc       = at_top;
    assign count_n  = ~count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            carry    <= 1'b0;
            load_err <= 1'b0;
            wrap_cnt <= '0;
        end else if (load) begin
            carry <= 1'b0;
            if (load_oor) begin
                count    <= TOP;
                load_err <= 1'b1;
            end else begin
                count    <= load_val;
                load_err <= 1'b0;
            end
        end else if (en) begin
            load_err <= 1'b0;
            if (at_top) begin
`ifdef SYNC_UP_COUNTER_SAT_EN
                count <= TOP;
                carry <= 1'b0;
`else
                count    <= '0;
                carry    <= 1'b1;
                wrap_cnt <= wrap_cnt + WRAPW'(1);
`endif
            end else begin
                count <= count + WIDTH'(1);
                carry <= 1'b0;
            end
        end else begin
            carry    <= 1'b0;
            load_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_up_counter.sv
// tb/tb_sync_up_counter.sv - randomized and directed bench for sync_up_counter against an integer model
module tb_sync_up_counter;

`ifdef SYNC_UP_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance a: WIDTH 6, MODULUS 64 (natural-overflow wrap)
    logic       r_a = 1'b1, en_a = 1'b0, ld_a = 1'b0;
    logic [5:0] lv_a = '0;
    logic [5:0] cnt_a, cntn_a;
    logic       tc_a, carry_a, lerr_a;
    logic [7:0] wrap_a;
    int ma_cnt = 0, ma_wrap = 0, ma_carry = 0, ma_lerr = 0;

    // Instance b: WIDTH 4, MODULUS 10
    logic       r_b = 1'b1, en_b = 1'b0, ld_b = 1'b0;
    logic [3:0] lv_b = '0;
    logic [3:0] cnt_b, cntn_b;
    logic       tc_b, carry_b, lerr_b;
    logic [7:0] wrap_b;
    int mb_cnt = 0, mb_wrap = 0, mb_carry = 0, mb_lerr = 0;

    // Cascade: two MODULUS-64 stages, upper enabled by lower en & tc
    logic       r_c = 1'b1, en_c = 1'b0, en_hi;
    logic [5:0] cnt_lo, cntn_lo, cnt_hi, cntn_hi;
    logic       tc_lo, carry_lo, lerr_lo, tc_hi, carry_hi, lerr_hi;
    logic [7:0] wrap_lo, wrap_hi;
    assign en_hi = en_c & tc_lo;

    sync_up_counter #(.WIDTH(6), .MODULUS(64), .WRAPW(8)) dut_a (
        .clk(clk), .reset(r_a), .en(en_a), .load(ld_a), .load_val(lv_a),
        .count(cnt_a), .count_n(cntn_a), .tc(tc_a), .carry(carry_a),
        .load_err(lerr_a), .wrap_cnt(wrap_a));

    sync_up_counter #(.WIDTH(4), .MODULUS(10), .WRAPW(8)) dut_b (
        .clk(clk), .reset(r_b), .en(en_b), .load(ld_b), .load_val(lv_b),
        .count(cnt_b), .count_n(cntn_b), .tc(tc_b), .carry(carry_b),
        .load_err(lerr_b), .wrap_cnt(wrap_b));

    sync_up_counter #(.WIDTH(6), .MODULUS(64), .WRAPW(8)) dut_lo (
        .clk(clk), .reset(r_c), .en(en_c), .load(1'b0), .load_val(6'd0),
        .count(cnt_lo), .count_n(cntn_lo), .tc(tc_lo), .carry(carry_lo),
        .load_err(lerr_lo), .wrap_cnt(wrap_lo));

    sync_up_counter #(.WIDTH(6), .MODULUS(64), .WRAPW(8)) dut_hi (
        .clk(clk), .reset(r_c), .en(en_hi), .load(1'b0), .load_val(6'd0),
        .count(cnt_hi), .count_n(cntn_hi), .tc(tc_hi), .carry(carry_hi),
        .load_err(lerr_hi), .wrap_cnt(wrap_hi));

    // Behavioural rule set: reset > load > en > hold, wrap counter modulo 256.
    task automatic ref_step(input int modulus, input bit r, input bit l, input bit e, input int lv,
                            inout int cnt, inout int wraps, output int carry, output int lerr);
        carry = 0;
        lerr  = 0;
        if (r) begin
            cnt   = 0;
            wraps = 0;
        end else if (l) begin
            if (lv >= modulus) begin
                cnt  = modulus - 1;
                lerr = 1;
            end else begin
                cnt = lv;
            end
        end else if (e) begin
            if (cnt == modulus - 1) begin
                if (!SAT) begin
                    cnt   = 0;
                    carry = 1;
                    wraps = (wraps + 1) % 256;
                end
            end else begin
                cnt = cnt + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_a(input bit r, input bit l, input bit e, input int lv);
        r_a = r; ld_a = l; en_a = e; lv_a = lv[5:0];
        ref_step(64, r, l, e, lv, ma_cnt, ma_wrap, ma_carry, ma_lerr);
        tick();
    endtask

    task automatic cyc_b(input bit r, input bit l, input bit e, input int lv);
        r_b = r; ld_b = l; en_b = e; lv_b = lv[3:0];
        ref_step(10, r, l, e, lv, mb_cnt, mb_wrap, mb_carry, mb_lerr);
        tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cyc_a(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 40);
            cyc_b(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12);
            n_cmp++;
            if (cnt_a !== 6'd0 || cntn_a !== 6'h3f || tc_a !== 1'b0 || carry_a !== 1'b0 ||
                lerr_a !== 1'b0 || wrap_a !== 8'd0) begin
                n_bad++;
                $display("FAIL reset_a: cnt=%0d cn=%0d tc=%b carry=%b lerr=%b wrap=%0d, required 0/63/0/0/0/0",
                         cnt_a, cntn_a, tc_a, carry_a, lerr_a, wrap_a);
            end
            n_cmp++;
            if (cnt_b !== 4'd0 || cntn_b !== 4'hf || tc_b !== 1'b0 || carry_b !== 1'b0 ||
                lerr_b !== 1'b0 || wrap_b !== 8'd0) begin
                n_bad++;
                $display("FAIL reset_b: cnt=%0d cn=%0d tc=%b carry=%b lerr=%b wrap=%0d, required 0/15/0/0/0/0",
                         cnt_b, cntn_b, tc_b, carry_b, lerr_b, wrap_b);
            end
        end
    endtask

    task automatic test_count64();
        int carries = 0;
        cyc_a(1'b1, 1'b0, 1'b0, 0);
        cyc_a(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 70; i++) begin
            cyc_a(1'b0, 1'b0, 1'b1, 0);
            if (carry_a === 1'b1) carries++;
            n_cmp++;
            if (cnt_a !== 6'(ma_cnt) || cntn_a !== 6'(63 - ma_cnt) || tc_a !== (ma_cnt == 63) ||
                carry_a !== 1'(ma_carry) || lerr_a !== 1'b0 || wrap_a !== 8'(ma_wrap)) begin
                n_bad++;
                $display("FAIL count64 step %0d: cnt=%0d cn=%0d tc=%b carry=%b wrap=%0d, required cnt=%0d carry=%0d wrap=%0d",
                         i, cnt_a, cntn_a, tc_a, carry_a, wrap_a, ma_cnt, ma_carry, ma_wrap);
            end
        end
        n_cmp++;
        if (carries != (SAT ? 0 : 1) || wrap_a !== (SAT ? 8'd0 : 8'd1) || cnt_a !== (SAT ? 6'd63 : 6'd6)) begin
            n_bad++;
            $display("FAIL count64_end: carries=%0d wrap=%0d cnt=%0d, required %0d/%0d/%0d",
                     carries, wrap_a, cnt_a, SAT ? 0 : 1, SAT ? 0 : 1, SAT ? 63 : 6);
        end
    endtask

    task automatic test_mod10();
        int carries = 0;
        cyc_b(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 25; i++) begin
            cyc_b(1'b0, 1'b0, 1'b1, 0);
            if (carry_b === 1'b1) carries++;
            n_cmp++;
            if (cnt_b !== 4'(mb_cnt) || cntn_b !== 4'(15 - mb_cnt) || tc_b !== (mb_cnt == 9) ||
                carry_b !== 1'(mb_carry) || lerr_b !== 1'b0 || wrap_b !== 8'(mb_wrap)) begin
                n_bad++;
                $display("FAIL mod10 step %0d: cnt=%0d tc=%b carry=%b wrap=%0d, required cnt=%0d carry=%0d wrap=%0d",
                         i, cnt_b, tc_b, carry_b, wrap_b, mb_cnt, mb_carry, mb_wrap);
            end
        end
        n_cmp++;
        if (carries != (SAT ? 0 : 2) || wrap_b !== (SAT ? 8'd0 : 8'd2)) begin
            n_bad++;
            $display("FAIL mod10_end: carries=%0d wrap=%0d, required %0d/%0d",
                     carries, wrap_b, SAT ? 0 : 2, SAT ? 0 : 2);
        end
    endtask

    task automatic test_load_priority();
        cyc_a(1'b0, 1'b1, 1'b0, 20);
        cyc_a(1'b0, 1'b1, 1'b1, 5);
        n_cmp++;
        if (cnt_a !== 6'd5 || carry_a !== 1'b0 || lerr_a !== 1'b0 || wrap_a !== 8'(ma_wrap)) begin
            n_bad++;
            $display("FAIL load_priority: cnt=%0d carry=%b lerr=%b wrap=%0d, required cnt=5 carry=0 lerr=0 wrap=%0d",
                     cnt_a, carry_a, lerr_a, wrap_a, ma_wrap);
        end
    endtask

    task automatic test_oor_load();
        cyc_b(1'b0, 1'b1, 1'b0, 12);
        n_cmp++;
        if (cnt_b !== 4'd9 || lerr_b !== 1'b1 || tc_b !== 1'b1 || carry_b !== 1'b0) begin
            n_bad++;
            $display("FAIL oor_load: cnt=%0d lerr=%b tc=%b carry=%b, required 9/1/1/0", cnt_b, lerr_b, tc_b, carry_b);
        end
        cyc_b(1'b0, 1'b0, 1'b1, 0);
        n_cmp++;
        if (cnt_b !== 4'(mb_cnt) || carry_b !== 1'(mb_carry) || lerr_b !== 1'b0 || wrap_b !== 8'(mb_wrap)) begin
            n_bad++;
            $display("FAIL oor_then_en: cnt=%0d carry=%b lerr=%b wrap=%0d, required cnt=%0d carry=%0d lerr=0 wrap=%0d",
                     cnt_b, carry_b, lerr_b, wrap_b, mb_cnt, mb_carry, mb_wrap);
        end
        cyc_b(1'b0, 1'b0, 1'b0, 0);
        n_cmp++;
        if (carry_b !== 1'b0 || lerr_b !== 1'b0 || cnt_b !== 4'(mb_cnt)) begin
            n_bad++;
            $display("FAIL oor_hold: cnt=%0d carry=%b lerr=%b, required cnt=%0d carry=0 lerr=0",
                     cnt_b, carry_b, lerr_b, mb_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_carry = 1'b0;
        cyc_a(1'b0, 1'b1, 1'b0, 63);
        cyc_a(1'b1, 1'b0, 1'b1, 0);
        n_cmp++;
        if (cnt_a !== 6'd0 || carry_a !== 1'b0 || wrap_a !== 8'd0 || lerr_a !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: cnt=%0d carry=%b wrap=%0d lerr=%b, required 0/0/0/0",
                     cnt_a, carry_a, wrap_a, lerr_a);
        end
        for (int i = 0; i < 3; i++) begin
            cyc_a(1'b0, 1'b0, 1'b0, 0);
            if (carry_a !== 1'b0) saw_carry = 1'b1;
        end
        n_cmp++;
        if (saw_carry || cnt_a !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_mid_after: saw_carry=%b cnt=%0d, required 0/0", saw_carry, cnt_a);
        end
    endtask

    task automatic test_enable_gap();
        bit en_seq[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        cyc_a(1'b0, 1'b1, 1'b0, 62);
        for (int i = 0; i < 4; i++) begin
            cyc_a(1'b0, 1'b0, en_seq[i], 0);
            n_cmp++;
            if (cnt_a !== 6'(ma_cnt) || carry_a !== 1'(ma_carry) || tc_a !== (ma_cnt == 63) ||
                wrap_a !== 8'(ma_wrap)) begin
                n_bad++;
                $display("FAIL enable_gap step %0d: cnt=%0d carry=%b tc=%b wrap=%0d, required cnt=%0d carry=%0d wrap=%0d",
                         i, cnt_a, carry_a, tc_a, wrap_a, ma_cnt, ma_carry, ma_wrap);
            end
        end
    endtask

    task automatic test_cascade();
        int lo = 0, hi = 0, lw = 0, hw = 0, lc = 0, hc = 0, le = 0, he = 0;
        bit hi_en;
        r_c = 1'b1; en_c = 1'b0;
        tick();
        r_c = 1'b0; en_c = 1'b1;
        for (int i = 0; i < 130; i++) begin
            hi_en = (lo == 63);
            ref_step(64, 1'b0, 1'b0, hi_en, 0, hi, hw, hc, he);
            ref_step(64, 1'b0, 1'b0, 1'b1, 0, lo, lw, lc, le);
            tick();
            n_cmp++;
            if (cnt_lo !== 6'(lo) || cnt_hi !== 6'(hi) || carry_lo !== 1'(lc) || carry_hi !== 1'(hc) ||
                wrap_hi !== 8'(hw) || lerr_lo !== 1'b0 || lerr_hi !== 1'b0) begin
                n_bad++;
                $display("FAIL cascade step %0d: lo=%0d hi=%0d clo=%b chi=%b whi=%0d, required lo=%0d hi=%0d clo=%0d chi=%0d whi=%0d",
                         i, cnt_lo, cnt_hi, carry_lo, carry_hi, wrap_hi, lo, hi, lc, hc, hw);
            end
        end
        en_c = 1'b0;
        n_cmp++;
        if (cnt_lo !== (SAT ? 6'd63 : 6'd2) || cnt_hi !== (SAT ? 6'd63 : 6'd2)) begin
            n_bad++;
            $display("FAIL cascade_end: lo=%0d hi=%0d, required %0d/%0d",
                     cnt_lo, cnt_hi, SAT ? 63 : 2, SAT ? 63 : 2);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit r, l, e;
            r = ($urandom_range(0, 31) == 0);
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            r_a = r; ld_a = l; en_a = e; lv_a = 6'($urandom_range(0, 63));
            ref_step(64, r, l, e, int'(lv_a), ma_cnt, ma_wrap, ma_carry, ma_lerr);
            r = ($urandom_range(0, 31) == 0);
            l = ($urandom_range(0, 5) == 0);
            e = ($urandom_range(0, 3) != 0);
            r_b = r; ld_b = l; en_b = e; lv_b = 4'($urandom_range(0, 15));
            ref_step(10, r, l, e, int'(lv_b), mb_cnt, mb_wrap, mb_carry, mb_lerr);
            tick();
            n_cmp++;
            if (cnt_a !== 6'(ma_cnt) || cntn_a !== 6'(63 - ma_cnt) || tc_a !== (ma_cnt == 63) ||
                carry_a !== 1'(ma_carry) || lerr_a !== 1'(ma_lerr) || wrap_a !== 8'(ma_wrap)) begin
                n_bad++;
                $display("FAIL random_a step %0d: cnt=%0d tc=%b carry=%b lerr=%b wrap=%0d, required cnt=%0d carry=%0d lerr=%0d wrap=%0d",
                         i, cnt_a, tc_a, carry_a, lerr_a, wrap_a, ma_cnt, ma_carry, ma_lerr, ma_wrap);
            end
            n_cmp++;
            if (cnt_b !== 4'(mb_cnt) || cntn_b !== 4'(15 - mb_cnt) || tc_b !== (mb_cnt == 9) ||
                carry_b !== 1'(mb_carry) || lerr_b !== 1'(mb_lerr) || wrap_b !== 8'(mb_wrap)) begin
                n_bad++;
                $display("FAIL random_b step %0d: cnt=%0d tc=%b carry=%b lerr=%b wrap=%0d, required cnt=%0d carry=%0d lerr=%0d wrap=%0d",
                         i, cnt_b, tc_b, carry_b, lerr_b, wrap_b, mb_cnt, mb_carry, mb_lerr, mb_wrap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count64();
        test_mod10();
        test_load_priority();
        test_oor_load();
        test_reset_mid();
        test_enable_gap();
        test_cascade();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
